// File: rtl/fifo_stim_gen.sv
// fifo_stim_gen: synthesizable FIFO write-port stimulus generator.
// Writes a block of len words into a FIFO write port and respects full.
// Write attempts are throttled by a 16-bit rate LFSR. Data comes from one of
// four internal pattern generators. The block is controlled by a
// start/busy/done handshake and can be cut short by abort.
//
// Handshake: a word is transferred on every rising edge where wren=1. wren is
// (state==RUN) && rate_pass && !full. It is combinational in full, so a FIFO
// that reports full in a given cycle never sees a write in that cycle. dout is
// valid whenever wren is high. Otherwise it holds the next word to be written.

module fifo_stim_gen #(
    parameter int          WIDTH     = 32,
    parameter int          LEN_W     = 10,
    parameter int          RATE_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  len,
    input  logic [RATE_W:0]   rate,
    input  logic [31:0]       seed,
    output logic [WIDTH-1:0]  dout,
    output logic              wren,
    input  logic              full,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    // FSM encoding; state is observable via busy/done and the state signal
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_RAND = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] GALOIS_TAPS = 32'h8020_0003;

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [RATE_W:0]   rate_q;
    logic [LEN_W-1:0]  count_q;
    logic [31:0]       data_q;
    logic [WIDTH-1:0]  walk_q;
    logic [15:0]       lfsr_q;

    logic              in_idle;
    logic              in_run;
    logic              launch;
    logic              rate_pass;
    logic              last_write;
    logic              lfsr_fb;
    logic [15:0]       lfsr_next;
    logic [31:0]       galois_next;
    logic [31:0]       data_next;
    logic [31:0]       seed_word;
    logic [WIDTH-1:0]  walk_next;
    logic [WIDTH-1:0]  rep_word;

    assign in_idle = (state == ST_IDLE);
    assign in_run  = (state == ST_RUN);
    // start is only honoured in IDLE. It wins over a coincident abort there
    // because abort is only looked at in RUN.
    assign launch  = in_idle && start;

    // Throttle decision: low RATE_W LFSR bits compared against the rate.
    // rate = 2^RATE_W therefore always passes, rate = 0 never does.
    assign rate_pass = ({1'b0, lfsr_q[RATE_W-1:0]} < rate_q);

    assign wren = in_run && rate_pass && !full;

    // This write makes count equal to len. The extra bit keeps the
    // maximum-length block from wrapping.
    assign last_write = wren &&
        (({1'b0, count_q} + (LEN_W+1)'(1)) == {1'b0, len_q});

    // Fibonacci rate LFSR, taps 16/14/13/11
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_next = {lfsr_fb, lfsr_q[15:1]};

    // Galois data LFSR step
    assign galois_next = {1'b0, data_q[31:1]} ^ (data_q[0] ? GALOIS_TAPS : 32'd0);

    // The all-zero state would lock the Galois LFSR, so seed 0 becomes 1 in mode 1
    assign seed_word = ((mode == MODE_RAND) && (seed == 32'd0)) ? 32'd1 : seed;

    // Rotate-left by one. For WIDTH=1 this keeps the single bit set.
    assign walk_next = (walk_q << 1) | (walk_q >> (WIDTH-1));

    // Advance of the 32-bit data register for the current pattern
    always_comb begin
        data_next = data_q;
        case (mode_q)
            MODE_INC:  data_next = data_q + 32'd1;
            MODE_RAND: data_next = galois_next;
            MODE_ALT:  data_next = ~data_q;
            default:   data_next = data_q;
        endcase
    end

    // Replicate the 32-bit data register across wide outputs, or truncate it for narrow ones
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rep
        assign rep_word[gi] = data_q[gi % 32];
    end

    // The walking-one pattern uses its own WIDTH-bit register so that it spans the full word
    assign dout  = (mode_q == MODE_WALK) ? walk_q : rep_word;
    assign busy  = in_run;
    assign done  = (state == ST_DONE);
    assign count = count_q;

    // Next-state logic: abort beats completion in RUN, DONE lasts one cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_write) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Block configuration, captured once at launch and held for the block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_INC;
            len_q  <= '0;
            rate_q <= '0;
        end else if (launch) begin
            mode_q <= mode;
            len_q  <= len;
            rate_q <= rate;
        end
    end

    // Accepted-word counter: cleared at launch and kept after the block ends or is aborted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (launch) begin
            count_q <= '0;
        end else if (wren) begin
            count_q <= count_q + LEN_W'(1);
        end
    end

    // Pattern registers: seeded at launch, advanced only on an accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            walk_q <= '0;
        end else if (launch) begin
            data_q <= seed_word;
            walk_q <= WIDTH'(1);
        end else if (wren) begin
            data_q <= data_next;
            walk_q <= walk_next;
        end
    end

    // Rate LFSR: advances on every RUN cycle, whether or not a write is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (in_run) begin
            lfsr_q <= lfsr_next;
        end
    end

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Testbench for fifo_stim_gen. The bench drives two instances, 32-bit and
// 8-bit wide, with the same stimulus. A spec-level model is compared with
// both instances on every cycle. Directed tests pin the model to
// hand-computed literal values.

module tb_fifo_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [9:0]  len = 10'd0;
    logic [8:0]  rate = 9'd0;
    logic [31:0] seed = 32'd0;
    logic        full = 1'b0;

    logic [31:0] dout32;
    logic        wren32, busy32, done32;
    logic [9:0]  count32;
    logic [7:0]  dout8;
    logic        wren8, busy8, done8;
    logic [9:0]  count8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] wq32[$];
    logic [31:0] wq8[$];

    fifo_stim_gen #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .len(len), .rate(rate), .seed(seed), .dout(dout32), .wren(wren32),
        .full(full), .busy(busy32), .done(done32), .count(count32)
    );

    fifo_stim_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .len(len), .rate(rate), .seed(seed), .dout(dout8), .wren(wren8),
        .full(full), .busy(busy8), .done(done8), .count(count8)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- spec-level model ----------------
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    bit          m_started = 1'b0;
    int          m_k = 0;
    logic [9:0]  m_len = '0;
    logic [9:0]  m_count = '0;
    logic [8:0]  m_rate = '0;
    logic [1:0]  m_mode = '0;
    logic [31:0] m_seed = '0;
    logic [31:0] m_rand = '0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [31:0] galois_step(input logic [31:0] r);
        if (r[0]) return (r >> 1) ^ 32'h8020_0003;
        return r >> 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        logic fb;
        fb = r[0] ^ r[2] ^ r[3] ^ r[5];
        return {fb, r[15:1]};
    endfunction

    function automatic logic m_pass();
        return ({1'b0, m_lfsr[7:0]} < m_rate);
    endfunction

    // Word k of the current block, for an output of width w
    function automatic logic [31:0] exp_word(input int w);
        if (!m_started) return 32'd0;
        case (m_mode)
            2'd0: return m_seed + 32'(m_k);
            2'd1: return m_rand;
            2'd2: return 32'd1 << (m_k % w);
            default: return ((m_k % 2) == 0) ? m_seed : ~m_seed;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        logic ew;
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_started <= 1'b0;
            m_k       <= 0;
            m_count   <= '0;
            m_mode    <= '0;
            m_lfsr    <= 16'hACE1;
        end else begin
            ew = m_active && m_pass() && !full;
            m_done <= 1'b0;
            if (m_active) begin
                m_lfsr <= lfsr_step(m_lfsr);
                if (ew) begin
                    m_count <= m_count + 10'd1;
                    m_k     <= m_k + 1;
                    m_rand  <= galois_step(m_rand);
                end
                if (abort) begin
                    m_active <= 1'b0;
                end else if (ew && (int'(m_count) + 1 == int'(m_len))) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end else if (!m_done && start) begin
                m_mode    <= mode;
                m_len     <= len;
                m_rate    <= rate;
                m_seed    <= seed;
                m_rand    <= (seed == 32'd0) ? 32'd1 : seed;
                m_count   <= '0;
                m_k       <= 0;
                m_started <= 1'b1;
                if (len == 10'd0) m_done <= 1'b1;
                else m_active <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin : cmp
        logic [31:0] e32;
        logic [31:0] e8;
        logic        ew;
        if (chk_en) begin
            ew  = m_active && m_pass() && !full;
            e32 = exp_word(32);
            e8  = exp_word(8);
            chk("wren32", wren32, ew);
            chk("busy32", busy32, m_active);
            chk("done32", done32, m_done);
            chk("count32", count32, m_count);
            chk("dout32", dout32, e32);
            chk("wren8", wren8, ew);
            chk("busy8", busy8, m_active);
            chk("done8", done8, m_done);
            chk("count8", count8, m_count);
            chk("dout8", dout8, e8[7:0]);
        end
    end

    // Write monitor: records the words the FIFO would accept
    always @(negedge clk) begin
        if (wren32) wq32.push_back(dout32);
        if (wren8) wq8.push_back({24'd0, dout8});
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one cycle. On return the bench is in the first cycle after start.
    task automatic launch(input logic [1:0] m, input logic [9:0] l,
                          input logic [8:0] r, input logic [31:0] s);
        mode  = m;
        len   = l;
        rate  = r;
        seed  = s;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!done32 && n < budget) begin
            step(1);
            n++;
        end
        chk(name, done32, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int nb;
        logic [31:0] walk_exp[10];
        logic [31:0] rand_exp[4];

        walk_exp = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10,
                     32'h20, 32'h40, 32'h80, 32'h01, 32'h02};
        rand_exp = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

        // reset
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk_en = 1'b1;
        chk("rst_count", count32, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_wren", wren32, 0);
        chk("rst_dout", dout32, 0);

        // basic incrementing run
        wq32.delete();
        launch(2'd0, 10'd8, 9'd256, 32'd100);
        for (int k = 0; k < 8; k++) begin
            chk("t1_wren", wren32, 1);
            chk("t1_dout", dout32, 100 + k);
            step(1);
        end
        chk("t1_done", done32, 1);
        chk("t1_count", count32, 8);
        chk("t1_wren_end", wren32, 0);
        step(1);
        chk("t1_done_once", done32, 0);

        // backpressure: full during cycles 3..5 after start
        wq32.delete();
        launch(2'd0, 10'd8, 9'd256, 32'd100);
        step(2);
        full = 1'b1;
        #1;
        chk("t2_full_wren", wren32, 0);
        chk("t2_full_dout", dout32, 102);
        step(3);
        full = 1'b0;
        wait_done(20, "t2_done");
        chk("t2_nwr", wq32.size(), 8);
        for (int k = 0; k < 8 && k < wq32.size(); k++) chk("t2_word", wq32[k], 100 + k);
        step(1);

        // throttle statistics, pseudo-random pattern
        wq32.delete();
        launch(2'd1, 10'd1000, 9'd64, 32'd1);
        w = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wren32) w++;
            step(1);
        end
        chk("t3_rate_band", (w >= 200 && w <= 300), 1);
        wait_done(6000, "t3_done");
        chk("t3_count", count32, 1000);
        chk("t3_nwr", wq32.size(), 1000);
        for (int k = 0; k < 4 && k < wq32.size(); k++) chk("t3_rand", wq32[k], rand_exp[k]);
        step(1);

        // rate 0: never writes, stays busy
        launch(2'd0, 10'd4, 9'd0, 32'd0);
        w = 0;
        nb = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wren32) w++;
            if (!busy32) nb++;
            step(1);
        end
        chk("t3_rate0_wr", w, 0);
        chk("t3_rate0_busy", nb, 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t3_rate0_abort_busy", busy32, 0);
        chk("t3_rate0_abort_done", done32, 0);

        // walking one on the 8-bit instance
        wq8.delete();
        launch(2'd2, 10'd10, 9'd256, 32'hDEAD_BEEF);
        wait_done(20, "t4_walk_done");
        chk("t4_walk_n", wq8.size(), 10);
        for (int k = 0; k < 10 && k < wq8.size(); k++) chk("t4_walk", wq8[k], walk_exp[k]);
        step(1);

        // alternating pattern
        wq32.delete();
        launch(2'd3, 10'd3, 9'd256, 32'h0F0F_0F0F);
        wait_done(20, "t4_alt_done");
        chk("t4_alt_n", wq32.size(), 3);
        if (wq32.size() == 3) begin
            chk("t4_alt0", wq32[0], 32'h0F0F_0F0F);
            chk("t4_alt1", wq32[1], 32'hF0F0_F0F0);
            chk("t4_alt2", wq32[2], 32'h0F0F_0F0F);
        end
        step(1);

        // len = 0: done with no writes
        wq32.delete();
        launch(2'd0, 10'd0, 9'd256, 32'd5);
        chk("t5_len0_done", done32, 1);
        chk("t5_len0_wren", wren32, 0);
        step(1);
        chk("t5_len0_done_once", done32, 0);
        chk("t5_len0_nwr", wq32.size(), 0);

        // start during RUN is ignored
        wq32.delete();
        launch(2'd0, 10'd6, 9'd256, 32'd200);
        step(2);
        mode  = 2'd3;
        len   = 10'd2;
        seed  = 32'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(20, "t5_restart_done");
        chk("t5_restart_count", count32, 6);
        chk("t5_restart_n", wq32.size(), 6);
        for (int k = 0; k < 6 && k < wq32.size(); k++) chk("t5_restart_word", wq32[k], 200 + k);
        step(1);

        // abort together with the 5th write of a 20-word block
        launch(2'd0, 10'd20, 9'd256, 32'd0);
        step(4);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_abort_busy", busy32, 0);
        chk("t5_abort_count", count32, 5);
        chk("t5_abort_wren", wren32, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_abort_nodone", done32, 0);
            step(1);
        end

        // abort coincident with the last write
        launch(2'd0, 10'd4, 9'd256, 32'd0);
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_abort_last_count", count32, 4);
        chk("t5_abort_last_done", done32, 0);
        chk("t5_abort_last_busy", busy32, 0);
        step(1);
        chk("t5_abort_last_done2", done32, 0);

        // asynchronous reset in the middle of a block
        launch(2'd0, 10'd20, 9'd256, 32'd50);
        step(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wren", wren32, 0);
        chk("t6_rst_busy", busy32, 0);
        chk("t6_rst_count", count32, 0);
        chk("t6_rst_dout", dout32, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wq32.delete();
        launch(2'd0, 10'd3, 9'd256, 32'd7);
        wait_done(20, "t6_after_done");
        chk("t6_after_n", wq32.size(), 3);
        for (int k = 0; k < 3 && k < wq32.size(); k++) chk("t6_after_word", wq32[k], 7 + k);
        step(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
